// File: rtl/mfcc_pkg.sv
// Shared MFCC types plus the 256-bit DRAM word layout used by the frame archiver.
package mfcc_pkg;

   localparam int          NUM_COEFFICIENTS = 12;
   localparam int          MFCC_WORD_WIDTH  = 256;
   localparam logic [31:0] MFCC_MAGIC       = 32'h4D46_4343;

   typedef struct packed {
      logic [31:0] mfcc_sample;
   } mfcc_data_t;

   typedef mfcc_data_t [NUM_COEFFICIENTS-1:0] mfcc_frame_t;

   typedef enum logic [1:0] {
      ST_WAIT_INIT = 2'd0,
      ST_IDLE      = 2'd1,
      ST_WRITE     = 2'd2
   } wr_state_t;

   // Low 16 bits of each coefficient, then the sequence number, then the tag.
   function automatic logic [MFCC_WORD_WIDTH-1:0] pack_mfcc_word(
      input mfcc_frame_t coefs,
      input logic [31:0] seq
   );
      logic [MFCC_WORD_WIDTH-1:0] word;
      word = '0;
      for (int k = 0; k < NUM_COEFFICIENTS; k++) begin
         word[16*k +: 16] = coefs[k].mfcc_sample[15:0];
      end
      word[223:192] = seq;
      word[255:224] = MFCC_MAGIC;
      return word;
   endfunction

endpackage

// File: rtl/mfcc_frame_queue.sv
// Synchronous FIFO of packed MFCC words; pointers carry an extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module mfcc_frame_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wptr_r;
   logic [AW:0]      rptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   // A push into a full queue is legal only when the head leaves in the same cycle.
   always_comb begin
      empty     = (wptr_r == rptr_r);
      full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      head      = mem_r[rptr_r[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wptr_r[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/mfcc_dram_writer.sv
// Archives every completed MFCC frame as one 256-bit word in a DDR ring
// through a Wishbone classic write master, with a small loss-counting queue.
module mfcc_dram_writer
   import mfcc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          NUM_WORDS   = 4096,
   parameter int          QUEUE_DEPTH = 4,
   parameter int          ACK_TIMEOUT = 1024,
   parameter logic [31:0] MAGIC       = MFCC_MAGIC
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable_i,
   input  logic                             initialized_i,
   input  logic                             mfcc_done_i,
   input  mfcc_data_t [NUM_COEFFICIENTS-1:0] mfcc_data_i,
   output logic                             wb_cyc_o,
   output logic                             wb_stb_o,
   output logic                             wb_we_o,
   output logic [31:0]                      wb_addr_o,
   output logic [31:0]                      wb_sel_o,
   output logic [MFCC_WORD_WIDTH-1:0]       wb_data_o,
   input  logic                             wb_ack_i,
   output logic [31:0]                      wr_ptr_o,
   output logic                             wrapped_o,
   output logic [31:0]                      frames_written_o,
   output logic [15:0]                      overflow_count_o,
   output logic [15:0]                      timeout_count_o
);

   localparam logic [31:0] PTR_LAST = 32'(NUM_WORDS - 1);
   localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);

   wr_state_t                  state_r;
   wr_state_t                  state_nxt_s;
   logic                       q_full_s;
   logic                       q_empty_s;
   logic [MFCC_WORD_WIDTH-1:0] q_head_s;
   logic [MFCC_WORD_WIDTH-1:0] push_word_s;
   logic                       push_s;
   logic                       drop_s;
   logic                       pop_s;
   logic                       start_s;
   logic                       timeout_s;
   logic [31:0]                tmo_cnt_r;
   logic [31:0]                seq_r;
   logic [31:0]                wr_ptr_r;
   logic [31:0]                frames_r;
   logic [15:0]                ovf_r;
   logic [15:0]                tmo_total_r;
   logic                       wrapped_r;
   logic                       cyc_r;
   logic [31:0]                addr_r;
   logic [31:0]                sel_r;
   logic [MFCC_WORD_WIDTH-1:0] data_r;

   // Word is built when the frame is accepted so the queue holds final data.
   always_comb begin
      push_word_s          = pack_mfcc_word(mfcc_data_i, seq_r);
      push_word_s[255:224] = MAGIC;
   end

   mfcc_frame_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (MFCC_WORD_WIDTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (push_word_s),
      .pop       (pop_s),
      .head      (q_head_s),
      .full      (q_full_s),
      .empty     (q_empty_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_WAIT_INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_WAIT_INIT: begin
            if (initialized_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_INIT;
            end
         end
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s = ST_WRITE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (pop_s || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         default: state_nxt_s = ST_WAIT_INIT;
      endcase
   end

   // Ack outranks the timeout on the final allowed cycle; acks outside WRITE are ignored.
   always_comb begin
      start_s   = 1'b0;
      pop_s     = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = !q_empty_s && enable_i;
         end
         ST_WRITE: begin
            pop_s     = wb_ack_i;
            timeout_s = !wb_ack_i && (tmo_cnt_r == TMO_LAST);
         end
         default: begin
            start_s   = 1'b0;
            pop_s     = 1'b0;
            timeout_s = 1'b0;
         end
      endcase
      push_s = mfcc_done_i && (!q_full_s || pop_s);
      drop_s = mfcc_done_i && !push_s;
   end

   // Bus signals are registered and frozen for the whole transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_r  <= 1'b0;
         sel_r  <= 32'h0000_0000;
         addr_r <= 32'h0000_0000;
         data_r <= '0;
      end else begin
         cyc_r <= (state_nxt_s == ST_WRITE);
         sel_r <= 32'hFFFF_FFFF;
         if (start_s) begin
            addr_r <= BASE_ADDR + wr_ptr_r;
            data_r <= q_head_s;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= 32'd0;
      end else if (state_r == ST_WRITE) begin
         tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end else begin
         tmo_cnt_r <= 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_r       <= 32'd0;
         wr_ptr_r    <= 32'd0;
         wrapped_r   <= 1'b0;
         frames_r    <= 32'd0;
         ovf_r       <= 16'd0;
         tmo_total_r <= 16'd0;
      end else begin
         if (push_s) begin
            seq_r <= seq_r + 32'd1;
         end
         if (drop_s && (ovf_r != 16'hFFFF)) begin
            ovf_r <= ovf_r + 16'd1;
         end
         if (timeout_s && (tmo_total_r != 16'hFFFF)) begin
            tmo_total_r <= tmo_total_r + 16'd1;
         end
         if (pop_s) begin
            frames_r <= frames_r + 32'd1;
            if (wr_ptr_r == PTR_LAST) begin
               wr_ptr_r  <= 32'd0;
               wrapped_r <= 1'b1;
            end else begin
               wr_ptr_r <= wr_ptr_r + 32'd1;
            end
         end
      end
   end

   assign wb_cyc_o         = cyc_r;
   assign wb_stb_o         = cyc_r;
   assign wb_we_o          = cyc_r;
   assign wb_addr_o        = addr_r;
   assign wb_sel_o         = sel_r;
   assign wb_data_o        = data_r;
   assign wr_ptr_o         = wr_ptr_r;
   assign wrapped_o        = wrapped_r;
   assign frames_written_o = frames_r;
   assign overflow_count_o = ovf_r;
   assign timeout_count_o  = tmo_total_r;

endmodule
